// File: rtl/mem_agent_pkg.sv
// mem_agent_pkg: FSM states and AXI constants shared by the burst read agent.
package mem_agent_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [3:0] CACHE_MODIF = 4'b0011;
    localparam int         BOUNDARY_4K = 4096;
endpackage

// File: rtl/mem_agent_burst_calc.sv
// mem_agent_burst_calc: beats in the next burst, capped by remaining count, MAX_BURST and the 4 KB page.
module mem_agent_burst_calc
    import mem_agent_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic [11:0]      page_off_i,
    input  logic [CNT_W-1:0] remaining_i,
    output logic [8:0]       len_o,
    output logic [7:0]       arlen_o
);
    localparam int SIZE = $clog2(DATA_W / 8);
    logic [12:0] to_page;
    logic [8:0]  rem_cap, page_cap;
    always_comb begin
        to_page  = (13'(BOUNDARY_4K) - {1'b0, page_off_i}) >> SIZE;
        rem_cap  = (32'(remaining_i) > 32'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(remaining_i);
        page_cap = (32'(to_page) > 32'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(to_page);
        len_o    = (rem_cap < page_cap) ? rem_cap : page_cap;
        arlen_o  = 8'(len_o - 9'd1);
    end
endmodule

// File: rtl/mem_agent_axi_burst.sv
// mem_agent_axi_burst: reads a linear span as a chain of 4 KB-safe AXI INCR bursts, one outstanding,
// forwarding R beats to a ready/valid stream with no added latency.
module mem_agent_axi_burst
    import mem_agent_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 1,
    parameter int USER_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [CNT_W-1:0]  beats_in,
    output logic [ID_W-1:0]   M_AXI_ARID,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    output logic              M_AXI_ARLOCK,
    output logic [3:0]        M_AXI_ARCACHE,
    output logic [2:0]        M_AXI_ARPROT,
    output logic [3:0]        M_AXI_ARQOS,
    output logic [USER_W-1:0] M_AXI_ARUSER,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [ID_W-1:0]   M_AXI_RID,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic [USER_W-1:0] M_AXI_RUSER,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              rd_valid_out,
    input  logic              rd_ready_in,
    output logic              rd_last_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out
);
    localparam int BYTES = DATA_W / 8;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [8:0]        bcnt_q, bcnt_d, len;
    logic              err_q, err_d, in_data, r_hs, unused_rsb;

    mem_agent_burst_calc #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_calc (
        .page_off_i  (addr_q[11:0]),
        .remaining_i (rem_q),
        .len_o       (len),
        .arlen_o     (M_AXI_ARLEN)
    );

    assign unused_rsb    = ^{M_AXI_RID, M_AXI_RUSER};
    assign in_data       = state_q == S_DATA;
    assign r_hs          = in_data && M_AXI_RVALID && rd_ready_in;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARSIZE  = 3'($clog2(BYTES));
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = CACHE_MODIF;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARUSER  = '0;
    assign M_AXI_ARVALID = state_q == S_ADDR;
    assign M_AXI_RREADY  = in_data && rd_ready_in;
    assign rd_data_out   = M_AXI_RDATA;
    assign rd_valid_out  = in_data && M_AXI_RVALID;
    assign rd_last_out   = rd_valid_out && (rem_q == CNT_W'(1));
    assign busy_out      = state_q != S_IDLE;
    assign done_out      = state_q == S_DONE;
    assign err_out       = err_q;

    // RLAST, not the beat count, decides where a burst ends; count mismatches only flag an error
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        bcnt_d  = bcnt_q;
        err_d   = err_q;
        if (state_q == S_IDLE && start_in) begin
            state_d = (beats_in == '0) ? S_DONE : S_ADDR;
            addr_d  = base_addr_in;
            rem_d   = beats_in;
            err_d   = 1'b0;
        end
        if (state_q == S_ADDR && M_AXI_ARREADY) begin
            state_d = S_DATA;
            bcnt_d  = len;
        end
        if (r_hs) begin
            addr_d  = addr_q + ADDR_W'(BYTES);
            rem_d   = (rem_q == '0) ? rem_q : rem_q - CNT_W'(1);
            bcnt_d  = (bcnt_q == '0) ? bcnt_q : bcnt_q - 9'd1;
            err_d   = err_q || (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RLAST != (bcnt_q == 9'd1));
            state_d = !M_AXI_RLAST ? S_DATA : (rem_d == '0) ? S_DONE : S_ADDR;
        end
        if (state_q == S_DONE) state_d = S_IDLE;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end
endmodule
